// File: rtl/output_packer.sv
// -----------------------------------------------------------------------------
// output_packer
//
// Packs a stream of byte-wide quantized results into 32-bit words and stores
// them in a FIFO for later readout. Results are packed little-endian: result
// k of a word lands in bits [8k+7:8k]. A partial word can be pushed early with
// flush; unused upper lanes of a flushed word are zero.
//
// Handshake semantics:
//   in_valid  one-cycle strobe; in_data[BYTE_SIZE-1:0] is captured on that edge.
//   rd_en     request to pop; when the FIFO holds a word, rd_data/rd_valid
//             present it on the following cycle (registered, latency 1).
//             When the FIFO is empty the request is ignored: rd_valid stays
//             low and rd_data keeps its previous value.
//   No backpressure exists on the input side. A word that completes while the
//   FIFO is full, with no pop in the same cycle, is dropped and sets the
//   sticky overflow flag.
//
// Priority, highest first: rst_n, en (low freezes everything), clear,
// then in_valid / flush / rd_en.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   en        global enable; low holds all state and forces rd_valid low
//   in_valid  result strobe
//   in_data   result; only the low BYTE_SIZE bits are used
//   flush     push the partial word, if any
//   clear     soft clear of FIFO, lane counter and overflow flag
//   rd_en     pop request
//   rd_data   popped word
//   rd_valid  one-cycle pulse qualifying rd_data
//   count     number of stored words (0..FIFO_DEPTH)
//   empty     count == 0
//   full      count == FIFO_DEPTH
//   lane      number of bytes held in the partial word
//   overflow  sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module output_packer #(
    parameter int BYTE_SIZE  = 8,
    parameter int INT32_SIZE = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic [INT32_SIZE-1:0]       in_data,
    input  logic                        flush,
    input  logic                        clear,
    input  logic                        rd_en,
    output logic [INT32_SIZE-1:0]       rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        empty,
    output logic                        full,
    output logic [1:0]                  lane,
    output logic                        overflow
);

    // The 2-bit lane output implies four lanes per word.
    localparam int LANES = INT32_SIZE / BYTE_SIZE;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [1:0]    LAST_LANE = 2'(LANES - 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [1:0]            lane_q,     lane_d;
    logic [INT32_SIZE-1:0] pack_q,     pack_d;
    logic [AW-1:0]         wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]         count_q,    count_d;
    logic                  full_q,     full_d;
    logic                  empty_q,    empty_d;
    logic                  overflow_q, overflow_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [INT32_SIZE-1:0] rd_data_q,  rd_data_d;

    // Storage is deliberately not reset; pointers and count define validity.
    logic [INT32_SIZE-1:0] mem_q [FIFO_DEPTH];

    // ---------------------------------------------------------------------
    // Datapath decode
    // ---------------------------------------------------------------------
    logic [BYTE_SIZE-1:0]  in_byte;
    logic                  active;
    logic                  push_req;
    logic                  pop_ok;
    logic                  wr_ok;
    logic [INT32_SIZE-1:0] push_word;

    // Upper result bits carry no information for this block.
    logic unused_in_bits;
    assign unused_in_bits = ^in_data[INT32_SIZE-1:BYTE_SIZE];

    always_comb begin
        in_byte = in_data[BYTE_SIZE-1:0];
        active  = en && !clear;

        // A word leaves the packer when the last lane fills, or on flush if
        // there is at least one byte (held or arriving this cycle).
        push_req = active &&
                   ((in_valid && (lane_q == LAST_LANE)) ||
                    (flush && (in_valid || (lane_q != 2'd0))));

        // Pop is evaluated before push, so a pop on an empty FIFO is a
        // no-op even when a push lands in the same cycle.
        pop_ok = active && rd_en && !empty_q;

        // A push while full survives only if a pop frees a slot this cycle.
        wr_ok = push_req && (!full_q || pop_ok);
    end

    // Held bytes plus the incoming byte at the current lane. Lanes above the
    // current one are always zero in pack_q, so a flushed word is zero-padded.
    always_comb begin
        push_word = pack_q;
        for (int k = 0; k < LANES; k++) begin
            if (in_valid && (lane_q == 2'(k))) begin
                push_word[k*BYTE_SIZE +: BYTE_SIZE] = in_byte;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        lane_d     = lane_q;
        pack_d     = pack_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (en) begin
            if (clear) begin
                lane_d     = 2'd0;
                pack_d     = '0;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                count_d    = '0;
                overflow_d = 1'b0;
            end else begin
                // Packing side
                if (push_req) begin
                    lane_d = 2'd0;
                    pack_d = '0;
                end else if (in_valid) begin
                    lane_d = lane_q + 2'd1;
                    pack_d = push_word;
                end

                // FIFO read side
                if (pop_ok) begin
                    rd_data_d  = mem_q[rd_ptr_q];
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                end

                // FIFO write side; pointers wrap modulo FIFO_DEPTH naturally
                if (wr_ok) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end

                if (push_req && !wr_ok) begin
                    overflow_d = 1'b1;
                end

                count_d = count_q + CW'(wr_ok) - CW'(pop_ok);
            end
        end

        // Flags registered from the next count so they agree with count.
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q     <= 2'd0;
            pack_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign lane     = lane_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_output_packer.sv
// -----------------------------------------------------------------------------
// tb_output_packer
//
// Self-checking bench for output_packer. A queue-based model of the packer
// (list of held bytes, list of stored words) is stepped on every rising edge
// and compared against all DUT outputs on every falling edge. Directed
// scenarios add hand-computed literal expectations; a randomized phase then
// exercises arbitrary mixes of the controls.
// -----------------------------------------------------------------------------
module tb_output_packer;

    localparam int DEPTH = 16;

    // ---------------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        flush = 1'b0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic [1:0]  lane;
    logic        overflow;

    always #5 clk = ~clk;

    output_packer #(
        .BYTE_SIZE (8),
        .INT32_SIZE(32),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_valid(in_valid),
        .in_data (in_data),
        .flush   (flush),
        .clear   (clear),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .lane    (lane),
        .overflow(overflow)
    );

    // ---------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: bytes waiting to be packed, words stored, read output
    // ---------------------------------------------------------------------
    logic [31:0] exp_q[$];
    logic [7:0]  part_q[$];
    logic        m_ovf = 1'b0;
    logic        m_rd_valid = 1'b0;
    logic [31:0] m_rd_data = '0;
    logic        model_live = 1'b0;

    always @(posedge clk) begin
        logic [7:0]  bytes[$];
        logic [31:0] w;
        model_live = 1'b1;
        if (!rst_n) begin
            exp_q.delete();
            part_q.delete();
            m_ovf      = 1'b0;
            m_rd_valid = 1'b0;
            m_rd_data  = '0;
        end else if (!en) begin
            m_rd_valid = 1'b0;
        end else if (clear) begin
            exp_q.delete();
            part_q.delete();
            m_ovf      = 1'b0;
            m_rd_valid = 1'b0;
        end else begin
            m_rd_valid = 1'b0;
            if (rd_en && exp_q.size() > 0) begin
                m_rd_data  = exp_q.pop_front();
                m_rd_valid = 1'b1;
            end
            bytes = part_q;
            if (in_valid) bytes.push_back(in_data[7:0]);
            if (bytes.size() == 4 || (flush && bytes.size() > 0)) begin
                w = '0;
                foreach (bytes[k]) w |= 32'(bytes[k]) << (8 * k);
                if (exp_q.size() < DEPTH) exp_q.push_back(w);
                else m_ovf = 1'b1;
                part_q.delete();
            end else begin
                part_q = bytes;
            end
        end
    end

    // One compare process against the model on every cycle.
    always @(negedge clk) begin
        if (model_live) begin
            check("count",    32'(count),    32'(exp_q.size()));
            check("empty",    32'(empty),    32'(exp_q.size() == 0));
            check("full",     32'(full),     32'(exp_q.size() == DEPTH));
            check("lane",     32'(lane),     32'(part_q.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            check("rd_data",  rd_data,       m_rd_data);
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks (called at a falling edge, return at the next one)
    // ---------------------------------------------------------------------
    task automatic drive(input logic v, input logic [31:0] d, input logic f,
                         input logic c, input logic r);
        in_valid = v;
        in_data  = d;
        flush    = f;
        clear    = c;
        rd_en    = r;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        clear    = 1'b0;
        rd_en    = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic r);
        logic [31:0] d;
        d      = $urandom;   // garbage in the ignored upper bits
        d[7:0] = b;
        drive(1'b1, d, 1'b0, 1'b0, r);
    endtask

    // Pushes one full word; optionally raises rd_en on the completing byte.
    task automatic push_word(input logic [31:0] w, input logic rd_on_last);
        for (int k = 0; k < 4; k++) begin
            push_byte(w[8*k +: 8], rd_on_last && (k == 3));
        end
    endtask

    task automatic do_read();
        drive(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_clear();
        drive(1'b0, $urandom, 1'b0, 1'b1, 1'b0);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    logic [31:0] words[20];

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_count",    32'(count),    32'd0);
        check("reset_empty",    32'(empty),    32'd1);
        check("reset_full",     32'(full),     32'd0);
        check("reset_lane",     32'(lane),     32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data",  rd_data,       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Four bytes make one word; read it back with latency one
        push_word(32'h04030201, 1'b0);
        check("four_bytes_count", 32'(count), 32'd1);
        do_read();
        check("four_bytes_valid", 32'(rd_valid), 32'd1);
        check("four_bytes_data",  rd_data,       32'h04030201);
        @(negedge clk);
        check("valid_one_cycle", 32'(rd_valid), 32'd0);

        // Read while empty: no pulse, data held
        do_read();
        check("empty_read_valid", 32'(rd_valid), 32'd0);
        check("empty_read_hold",  rd_data,       32'h04030201);

        // Partial word via flush, then a redundant flush
        push_byte(8'hFF, 1'b0);
        push_byte(8'h80, 1'b0);
        check("partial_lane", 32'(lane), 32'd2);
        drive(1'b0, $urandom, 1'b1, 1'b0, 1'b0);
        check("flush_lane",  32'(lane),  32'd0);
        check("flush_count", 32'(count), 32'd1);
        drive(1'b0, $urandom, 1'b1, 1'b0, 1'b0);
        check("flush2_count", 32'(count), 32'd1);
        check("flush2_lane",  32'(lane),  32'd0);
        do_read();
        check("flush_data", rd_data, 32'h000080FF);

        // in_valid together with flush: one word including the new byte
        push_byte(8'h11, 1'b0);
        drive(1'b1, 32'hABCDEF22, 1'b1, 1'b0, 1'b0);
        check("vflush_count", 32'(count), 32'd1);
        check("vflush_lane",  32'(lane),  32'd0);
        do_read();
        check("vflush_data", rd_data, 32'h00002211);

        // 17 words into a 16-deep FIFO: the last one is dropped
        do_clear();
        for (int i = 0; i < 17; i++) begin
            words[i] = $urandom;
            push_word(words[i], 1'b0);
        end
        check("ovf_full",     32'(full),     32'd1);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_count",    32'(count),    32'd16);
        for (int i = 0; i < 16; i++) begin
            do_read();
            check("ovf_readback", rd_data, words[i]);
        end
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop together while full, 20 words across the wrap
        do_clear();
        check("clear_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 20; i++) words[i] = $urandom;
        for (int i = 0; i < 16; i++) push_word(words[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_word(words[16 + i], 1'b1);
            check("pp_count",    32'(count),    32'd16);
            check("pp_overflow", 32'(overflow), 32'd0);
            check("pp_data",     rd_data,       words[i]);
        end
        for (int i = 4; i < 20; i++) begin
            do_read();
            check("wrap_data", rd_data, words[i]);
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Clear beats in_valid
        push_word($urandom, 1'b0);
        push_word($urandom, 1'b0);
        push_byte($urandom, 1'b0);
        push_byte($urandom, 1'b0);
        check("pre_clear_lane", 32'(lane), 32'd2);
        drive(1'b1, $urandom, 1'b0, 1'b1, 1'b1);
        check("clear_count", 32'(count), 32'd0);
        check("clear_lane",  32'(lane),  32'd0);
        check("clear_ovf",   32'(overflow), 32'd0);
        check("clear_rdv",   32'(rd_valid), 32'd0);

        // Reset during a read and mid-word
        push_word(32'hCAFEF00D, 1'b0);
        push_byte(8'h5A, 1'b0);
        rd_en = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_read_valid", 32'(rd_valid), 32'd0);
        check("rst_read_lane",  32'(lane),     32'd0);
        check("rst_read_count", 32'(count),    32'd0);
        rd_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // en low freezes everything
        push_word(32'h13572468, 1'b0);
        push_byte(8'h77, 1'b0);
        en = 1'b0;
        in_valid = 1'b1;
        rd_en    = 1'b1;
        flush    = 1'b1;
        clear    = 1'b1;
        repeat (3) @(negedge clk);
        check("en_count", 32'(count),    32'd1);
        check("en_lane",  32'(lane),     32'd1);
        check("en_rdv",   32'(rd_valid), 32'd0);
        in_valid = 1'b0;
        rd_en    = 1'b0;
        flush    = 1'b0;
        clear    = 1'b0;
        en = 1'b1;
        @(negedge clk);

        // Randomized phases: read-light (fills/overflows), then read-heavy
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                rst_n    = ($urandom_range(0, 399) != 0);
                en       = ($urandom_range(0, 9) != 0);
                clear    = ($urandom_range(0, 149) == 0);
                flush    = ($urandom_range(0, 7) == 0);
                in_valid = ($urandom_range(0, 9) < 6);
                rd_en    = (ph == 0) ? ($urandom_range(0, 9) < 1)
                                     : ($urandom_range(0, 9) < 6);
                in_data  = $urandom;
                @(negedge clk);
            end
        end

        rst_n    = 1'b1;
        en       = 1'b1;
        clear    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
